// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and types for the register file and its busy scoreboard.
// No logic; the types carry the default widths.
// No flow control.
package reg_file_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [DW_DEF-1:0]   reg_data_t;
    typedef logic [NREG_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits (issue sets, writeback clears, set wins) and a registered busy count.
// Latency: busy and busy_cnt update on the clock edge after issue/writeback.
// No backpressure; the decode stage stalls on the busy bits it reads.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int AW      = $clog2(NREG),
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_nxt;
    logic            inc;
    logic            dec0;
    logic            dec1;
    logic [AW:0]     cnt_nxt;

    // Next busy vector plus the count delta: at most one set and two distinct clears per cycle.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            set_vec[r] = iss_valid && (iss_addr == AW'(r)) && !(ZERO_R0 && (r == 0));
            clr_vec[r] = (we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)));
        end
        busy_nxt = set_vec | (busy & ~clr_vec);
        inc      = |(set_vec & ~busy);
        dec0     = we0 && busy[wa0] && !set_vec[wa0];
        // Both ports writing the same register only release it once.
        dec1     = we1 && busy[wa1] && !set_vec[wa1] && !(we0 && (wa0 == wa1));
        cnt_nxt  = busy_cnt + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
    end

    // Busy state and count; reset dominates any same-cycle issue or writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-read, dual-write register file with optional write bypass, zero register and busy scoreboard.
// Latency: reads combinational (same-cycle bypass if enabled); writes and busy updates land next edge.
// No backpressure; rd_busy tells decode to stall on a pending writeback.
module reg_file_mp_sb
    import reg_file_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NR      = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [DW-1:0]    wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd1,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_addr,
    output logic [AW:0]      busy_cnt
);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;

    // Storage; port 1 is written last so it wins when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0 && !(ZERO_R0 && (wa0 == '0))) begin
                mem[wa0] <= wd0;
            end
            if (we1 && !(ZERO_R0 && (wa1 == '0))) begin
                mem[wa1] <= wd1;
            end
        end
    end

    reg_file_scoreboard #(
        .NREG    (NREG),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .we0       (we0),
        .wa0       (wa0),
        .we1       (we1),
        .wa1       (wa1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        logic          is_zero;
        logic [DW-1:0] d;
        logic          b;

        assign a = rd_addr[k*AW +: AW];

        // Read mux: zero register, then port 1 bypass, port 0 bypass, stored value.
        always_comb begin
            hit1    = BYPASS && we1 && (wa1 == a);
            hit0    = BYPASS && we0 && (wa0 == a);
            is_zero = ZERO_R0 && (a == '0);
            d       = mem[a];
            if (is_zero) begin
                d = '0;
            end else if (hit1) begin
                d = wd1;
            end else if (hit0) begin
                d = wd0;
            end
            // A same-cycle writeback releases the stall only when its data is being forwarded.
            b = busy[a] && !(hit0 || hit1) && !is_zero && !rst;
        end

        assign rd_data[k*DW +: DW] = d;
        assign rd_busy[k]          = b;
    end

endmodule
